// File: rtl/gost_pkg.sv
// Shared constants, state encoding and key-schedule helpers for the GOST 28147-89 cores.
package gost_pkg;
    localparam int ROUNDS  = 32;
    localparam int ROT_AMT = 11;
    localparam int KEY_W   = 32;
    localparam int BLK_W   = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Decryption: K0..K7 once, then K7..K0 three times.
    function automatic logic [2:0] dec_key_idx(input logic [4:0] r);
        return (r < 5'd8) ? r[2:0] : ~r[2:0];
    endfunction

    // Encryption: K0..K7 three times, then K7..K0.
    function automatic logic [2:0] enc_key_idx(input logic [4:0] r);
        return (r < 5'd24) ? r[2:0] : ~r[2:0];
    endfunction
endpackage

// File: rtl/replacer.sv
// Nibble-wise S-box substitution; nibble i uses row (i mod 8) of the tc26 "Z" table.
module replacer #(
    parameter int R_WIDTH = 32
) (
    input  logic [R_WIDTH-1:0] data_i,
    output logic [R_WIDTH-1:0] data_o
);
    // Each row packs 16 nibbles, entry for input value v at bits [4v+3:4v].
    localparam logic [63:0] SBOX [8] = '{
        64'h1F307D8E9B5A264C,
        64'hF0DB74E1C5A93286,
        64'h069C471EDAF2853B,
        64'hB9E35A076F4D128C,
        64'hC24BE390D618A5F7,
        64'h0E34187BAC296FD5,
        64'h73AD0B4FC19652E8,
        64'h2BC96AF43850DE71
    };

    for (genvar i = 0; i < R_WIDTH / 4; i++) begin : g_nib
        logic [63:0] row;
        assign row = SBOX[i % 8];
        assign data_o[4*i +: 4] = row[{data_i[4*i +: 4], 2'b00} +: 4];
    end
endmodule

// File: rtl/gost_decryptor.sv
// Iterative GOST 28147-89 (Magma) block decryptor: one Feistel round per clock, 32 rounds.
module gost_decryptor #(
    parameter int ROUNDS = 32
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [63:0]  data_i,
    input  logic [255:0] key_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [63:0]  data_o
);
    import gost_pkg::*;

    state_e                 state_q, state_d;
    logic [4:0]             cnt_q;
    logic [KEY_W-1:0]       a_q, b_q;
    logic [7:0][KEY_W-1:0]  key_q;     // key_q[7] = K0 ... key_q[0] = K7
    logic [KEY_W-1:0]       kr, sum, sub, rot, t;
    logic                   accept, last;

    assign accept = (state_q == IDLE) && valid_i;
    assign last   = (cnt_q == 5'(ROUNDS - 1));

    assign kr  = key_q[3'd7 - dec_key_idx(cnt_q)];
    assign sum = a_q + kr;

    replacer #(.R_WIDTH(KEY_W)) u_replacer (
        .data_i (sum),
        .data_o (sub)
    );

    assign rot = {sub[KEY_W-ROT_AMT-1:0], sub[KEY_W-1:KEY_W-ROT_AMT]};
    assign t   = rot ^ b_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = RUN;
            RUN:     if (last)    state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
    end

    // Counter wraps 31 -> 0 on the final round, so it is already clear in DONE.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q   <= '0;
            b_q   <= '0;
            key_q <= '0;
            cnt_q <= '0;
        end else if (accept) begin
            a_q   <= data_i[31:0];
            b_q   <= data_i[63:32];
            key_q <= key_i;
            cnt_q <= '0;
        end else if (state_q == RUN) begin
            a_q   <= t;
            b_q   <= a_q;
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign data_o = {a_q, b_q};
endmodule

// File: tb/tb_gost_decryptor.sv
// Self-checking bench for gost_decryptor against a software Magma model and RFC 8891 vectors.
module tb_gost_decryptor;
    logic         clk = 0;
    logic         rst_n;
    logic         valid_i, ready_i;
    logic         ready_o, valid_o;
    logic [63:0]  data_i, data_o;
    logic [255:0] key_i;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [255:0] REF_KEY = 256'hffeeddccbbaa99887766554433221100_f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  REF_CT  = 64'h4ee901e5c2d8ca3d;
    localparam logic [63:0]  REF_PT  = 64'hfedcba9876543210;

    gost_decryptor dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .key_i   (key_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    always #5 clk = ~clk;

    // tc26 "Z" S-boxes, Pi0..Pi7, in natural table order.
    localparam int SB [8][16] = '{
        '{12,4,6,2,10,5,11,9,14,8,13,7,0,3,15,1},
        '{6,8,2,3,9,10,5,12,1,14,4,7,11,13,0,15},
        '{11,3,5,8,2,15,10,13,14,1,7,4,12,9,6,0},
        '{12,8,2,1,13,4,15,6,7,0,10,5,3,14,9,11},
        '{7,15,5,10,8,1,6,13,0,9,3,14,11,4,2,12},
        '{5,13,15,6,9,2,12,10,11,7,8,1,4,3,14,0},
        '{8,14,2,5,6,9,1,12,15,4,11,0,13,10,3,7},
        '{1,7,14,13,0,5,8,3,4,15,10,6,9,12,11,2}
    };

    function automatic logic [31:0] t_sub(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 8; i++) r[4*i +: 4] = 4'(SB[i][int'(x[4*i +: 4])]);
        return r;
    endfunction

    function automatic logic [31:0] g_fn(input logic [31:0] k, input logic [31:0] a);
        logic [31:0] s;
        s = t_sub(a + k);
        return (s << 11) | (s >> 21);
    endfunction

    // Magma in RFC 8891 notation: (a1,a0) -> (a0, g(a0)^a1), no swap after the last round.
    function automatic logic [63:0] magma(input logic [63:0] blk, input logic [255:0] key, input bit dec);
        logic [31:0] k [8];
        int          sched [32];
        logic [31:0] a1, a0, tmp;
        for (int i = 0; i < 8; i++) k[i] = key[255 - 32*i -: 32];
        for (int i = 0; i < 32; i++)
            if (dec) sched[i] = (i < 8)  ? i : 7 - (i % 8);
            else     sched[i] = (i < 24) ? (i % 8) : 7 - (i % 8);
        a1 = blk[63:32];
        a0 = blk[31:0];
        for (int i = 0; i < 32; i++) begin
            tmp = a1 ^ g_fn(k[sched[i]], a0);
            a1  = a0;
            a0  = tmp;
        end
        return {a0, a1};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level expectation: one outstanding block, result 32 edges after accept.
    bit          m_pend;
    int          m_cnt;
    logic [63:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend = 0; m_cnt = 0; m_data = '0;
        end else if (m_pend) begin
            if (m_cnt >= 32 && ready_i) m_pend = 0;
            else                        m_cnt++;
        end else if (valid_i) begin
            m_pend = 1; m_cnt = 0; m_data = magma(data_i, key_i, 1'b1);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cmp_ready", {63'd0, ready_o}, {63'd0, !m_pend});
            chk("cmp_valid", {63'd0, valid_o}, {63'd0, m_pend && m_cnt >= 32});
            if (m_pend && m_cnt >= 32) chk("cmp_data", data_o, m_data);
        end
    end

    task automatic send(input logic [63:0] d, input logic [255:0] k, output longint acc_t);
        bit got = 0;
        @(posedge clk); #1;
        data_i = d; key_i = k; valid_i = 1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ready_o) got = 1;
        end
        if (!got) begin n_checks++; n_fail++; $display("FAIL accept_timeout: ready_o never high"); end
        @(posedge clk); acc_t = longint'($time); #1;
        valid_i = 0;
    endtask

    task automatic wait_result(output bit got, output longint t_v);
        got = 0; t_v = 0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (valid_o) begin got = 1; t_v = longint'($time); end
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL result_timeout: valid_o 0 expected 1"); end
    endtask

    initial begin
        longint ta, tv;
        bit     got;
        int     extra;
        logic [63:0]  p, c;
        logic [255:0] k;

        rst_n = 0; valid_i = 0; ready_i = 1; data_i = '0; key_i = '0;

        // Pin the model to RFC 8891 literals.
        chk("pin_t",   {32'd0, t_sub(32'hfdb97531)}, 64'h2a196f34);
        chk("pin_g",   {32'd0, g_fn(32'h87654321, 32'hfedcba98)}, 64'hfdcbc20c);
        chk("pin_enc", magma(REF_PT, REF_KEY, 1'b0), REF_CT);
        chk("pin_dec", magma(REF_CT, REF_KEY, 1'b1), REF_PT);

        #1;
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_data",  data_o, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // Reference vector and latency.
        send(REF_CT, REF_KEY, ta);
        wait_result(got, tv);
        chk("ref_data", data_o, REF_PT);
        chk("ref_latency", 64'((tv - ta - 5) / 10), 64'd32);
        @(negedge clk);

        // Backpressure: result held for 10 cycles.
        ready_i = 0;
        send(REF_CT, REF_KEY, ta);
        wait_result(got, tv);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", {63'd0, valid_o}, 64'd1);
            chk("bp_data",  data_o, REF_PT);
            chk("bp_ready", {63'd0, ready_o}, 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1 ready_i = 1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", {63'd0, ready_o}, 64'd1);
        chk("bp_idle_valid", {63'd0, valid_o}, 64'd0);

        // Busy rejection: junk valid_i throughout RUN.
        send(REF_CT, REF_KEY, ta);
        data_i = '0; key_i = '0; valid_i = 1;
        wait_result(got, tv);
        valid_i = 0;
        chk("busy_data", data_o, REF_PT);
        @(negedge clk);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid_o) extra++;
        end
        chk("busy_no_second", 64'(extra), 64'd0);

        // Asynchronous reset at round 15.
        send(REF_CT, REF_KEY, ta);
        repeat (15) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid", {63'd0, valid_o}, 64'd0);
        chk("mid_rst_data",  data_o, 64'd0);
        chk("mid_rst_ready", {63'd0, ready_o}, 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        send(REF_CT, REF_KEY, ta);
        wait_result(got, tv);
        chk("post_rst_data", data_o, REF_PT);
        @(negedge clk);

        // Zero key / zero block.
        send(64'd0, 256'd0, ta);
        wait_result(got, tv);
        chk("zero_data", data_o, magma(64'd0, 256'd0, 1'b1));
        @(negedge clk);

        // Round trip through the software encryptor.
        for (int n = 0; n < 100; n++) begin
            p = {$urandom, $urandom};
            for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
            c = magma(p, k, 1'b0);
            send(c, k, ta);
            wait_result(got, tv);
            chk("round_trip", data_o, p);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
